// File: rtl/hamming_correct_pipe.sv
// hamming_correct_pipe: two-stage registered Hamming(7,4) single-error corrector
// with valid/ready handshake and an optional saturating corrected-word counter.
// Optional feature macro: HAM_ERR_COUNT_EN (builds the err_count logic).
module hamming_correct_pipe #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic [2:0]       out_syndrome,
    output logic             out_corrected,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_count
);

    logic       v1;
    logic       v2;
    logic [6:0] code1;
    logic [2:0] syn1;
    logic [2:0] syn_in;
    logic [6:0] flip;
    logic [6:0] fixed;
    logic       adv1;
    logic       adv2;
    logic       unused_parity;

    // Syndrome {c3,c2,c1} of the incoming word
    assign syn_in = {in_code[3] ^ in_code[4] ^ in_code[5] ^ in_code[6],
                     in_code[1] ^ in_code[2] ^ in_code[5] ^ in_code[6],
                     in_code[0] ^ in_code[2] ^ in_code[4] ^ in_code[6]};

    // Stage advance: a stage may load when it is empty or its content moves on
    assign adv2      = !v2 || out_ready;
    assign adv1      = !v1 || adv2;
    assign in_ready  = adv1;
    assign out_valid = v2;

    // Single-bit flip mask: syndrome value names the 1-based erroneous position
    always_comb begin
        flip = '0;
        if (syn1 != 3'd0) begin
            flip = 7'(1) << (syn1 - 3'd1);
        end
        fixed = code1 ^ flip;
    end

    // Parity positions are only needed for the syndrome, not the data
    assign unused_parity = ^{fixed[3], fixed[1], fixed[0]};

    // Stage S1: raw codeword and its syndrome
    always_ff @(posedge clk) begin
        if (rst) begin
            v1    <= 1'b0;
            code1 <= '0;
            syn1  <= '0;
        end else if (adv1) begin
            v1    <= in_valid;
            code1 <= in_code;
            syn1  <= syn_in;
        end
    end

    // Stage S2: corrected nibble and status, held while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            v2            <= 1'b0;
            out_data      <= '0;
            out_syndrome  <= '0;
            out_corrected <= 1'b0;
        end else if (adv2) begin
            v2            <= v1;
            out_data      <= {fixed[6], fixed[5], fixed[4], fixed[2]};
            out_syndrome  <= syn1;
            out_corrected <= (syn1 != 3'd0);
        end
    end

`ifdef HAM_ERR_COUNT_EN
    // Saturating count of corrected words leaving the stage; clear has priority
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            err_count <= '0;
        end else if (v2 && out_ready && out_corrected && (err_count != {CNT_W{1'b1}})) begin
            err_count <= err_count + CNT_W'(1);
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_count      = '0;
`endif

endmodule
